// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a byte-wide single-port memory.
// Requester A (CPU) normally wins. Requester B (debug/loader) is served once A
// has taken STARVE_LIMIT grants in a row while B was waiting. Each transaction
// takes one or two memory beats. A one-cycle ack then returns the assembled
// 16-bit read data to the winning requester.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    input  logic        a_we,
    input  logic        a_word,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_ack,
    output logic [15:0] a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic        b_word,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic [15:0] b_rdata,

    output logic        m_en,
    output logic        m_we,
    output logic [15:0] m_addr,
    output logic [7:0]  m_wdata,
    input  logic [7:0]  m_rdata,

    output logic        busy,
    output logic        owner
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        RESP
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [SW-1:0] streak;
    logic          we_q;
    logic          word_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [7:0]    lo_q;
    logic [15:0]   a_rdata_q;
    logic [15:0]   b_rdata_q;
    logic          any_req;
    logic          grant_b;
    logic [15:0]   resp_data;

    // Arbitration: B wins when A is silent, or when A has starved B long enough.
    always_comb begin
        any_req = a_req | b_req;
        grant_b = b_req & (~a_req | (streak == LIMIT));
    end

    // Sequencing: one beat for a byte, two beats for a word, then the ack cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = LO;
            LO:      next_state = word_q ? HI : RESP;
            HI:      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Read data seen by the owner during its ack. The memory returns a byte one
    // cycle after the read beat, so the last byte arrives in RESP itself and is
    // passed straight through. It is also captured so that it stays stable afterwards.
    always_comb begin
        resp_data = 16'h0000;
        if (!we_q) begin
            if (word_q) resp_data = {m_rdata, lo_q};
            else        resp_data = {8'h00, m_rdata};
        end
    end

    // Memory drive and handshake outputs, decoded from state. Reset gates the
    // strobes immediately, so an interrupted access cannot write its high byte
    // or issue an ack.
    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = 16'h0000;
        m_wdata = 8'h00;
        a_ack   = 1'b0;
        b_ack   = 1'b0;
        case (state)
            LO: begin
                m_en    = ~rst;
                m_we    = ~rst & we_q;
                m_addr  = addr_q;
                m_wdata = wdata_q[7:0];
            end
            HI: begin
                m_en    = ~rst;
                m_we    = ~rst & we_q;
                m_addr  = addr_q + 16'd1;
                m_wdata = wdata_q[15:8];
            end
            RESP: begin
                a_ack = ~rst & ~owner;
                b_ack = ~rst & owner;
            end
            default: ;
        endcase
        busy    = (state != IDLE);
        a_rdata = a_ack ? resp_data : a_rdata_q;
        b_rdata = b_ack ? resp_data : b_rdata_q;
    end

    // State register, grant latching, starvation counter and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            streak    <= '0;
            owner     <= 1'b0;
            we_q      <= 1'b0;
            word_q    <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            lo_q      <= 8'h00;
            a_rdata_q <= 16'h0000;
            b_rdata_q <= 16'h0000;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= grant_b;
                        we_q    <= grant_b ? b_we    : a_we;
                        word_q  <= grant_b ? b_word  : a_word;
                        addr_q  <= grant_b ? b_addr  : a_addr;
                        wdata_q <= grant_b ? b_wdata : a_wdata;
                        if (grant_b || !b_req) begin
                            streak <= '0;
                        end else if (streak != LIMIT) begin
                            streak <= streak + SW'(1);
                        end
                    end
                end
                HI: begin
                    if (!we_q) lo_q <= m_rdata;
                end
                RESP: begin
                    if (owner) b_rdata_q <= resp_data;
                    else       a_rdata_q <= resp_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. A behavioural byte memory sits on the m_*
// port. A transaction-level model predicts three things: memory contents, the
// arbitration winner and the read data.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, a_word = 1'b0;
    logic [15:0] a_addr = '0, a_wdata = '0;
    logic        b_req = 1'b0, b_we = 1'b0, b_word = 1'b0;
    logic [15:0] b_addr = '0, b_wdata = '0;
    logic        a_ack, b_ack, m_en, m_we, busy, owner;
    logic [15:0] a_rdata, b_rdata, m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata = 8'h00;

    int err_count = 0;
    int check_count = 0;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_word(a_word), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_word(b_word), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Power-up contents, shared by the memory device and the reference model.
    function automatic logic [7:0] initByte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    // Behavioural synchronous byte memory: read data appears the cycle after.
    logic [7:0] mem [65536];
    bit mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) mem[i] <= initByte(16'(i));
            mem_ready <= 1'b1;
        end else if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata <= mem[m_addr];
        end
    end

    // Reference model state: expected memory, starvation count, held rdata.
    logic [7:0]  ref_mem [65536];
    int          model_streak = 0;
    logic [15:0] hold [2];

    // Returns 1 when B should win a grant with the given requests pending.
    function automatic bit modelGrant(input bit a, input bit b);
        bit win_b;
        win_b = b && (!a || model_streak == STARVE_LIMIT);
        if (win_b || !b) model_streak = 0;
        else if (model_streak < STARVE_LIMIT) model_streak = model_streak + 1;
        return win_b;
    endfunction

    function automatic logic [15:0] expRdata(input bit we, input bit word,
                                             input logic [15:0] addr);
        logic [15:0] nxt;
        nxt = addr + 16'd1;
        if (we) return 16'h0000;
        if (word) return {ref_mem[nxt], ref_mem[addr]};
        return {8'h00, ref_mem[addr]};
    endfunction

    task automatic applyRef(input bit we, input bit word, input logic [15:0] addr,
                            input logic [15:0] wdata);
        logic [15:0] nxt;
        nxt = addr + 16'd1;
        if (we) begin
            ref_mem[addr] = wdata[7:0];
            if (word) ref_mem[nxt] = wdata[15:8];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic setPort(input bit p, input bit req, input bit we, input bit word,
                           input logic [15:0] addr, input logic [15:0] wdata);
        if (!p) begin
            a_req = req; a_we = we; a_word = word; a_addr = addr; a_wdata = wdata;
        end else begin
            b_req = req; b_we = we; b_word = word; b_addr = addr; b_wdata = wdata;
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_ctrl", {26'b0, busy, owner, m_en, m_we, a_ack, b_ack}, 0);
        checkOutput("rst_m_addr", m_addr, 0);
        checkOutput("rst_m_wdata", m_wdata, 0);
        checkOutput("rst_a_rdata", a_rdata, 0);
        checkOutput("rst_b_rdata", b_rdata, 0);
    endtask

    task automatic checkIdleAfter();
        repeat (2) begin
            @(negedge clk);
            checkOutput("idle_after", {29'b0, busy, a_ack, b_ack}, 0);
        end
    endtask

    task automatic waitAck(output bit got);
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (a_ack || b_ack) got = 1'b1;
        end
    endtask

    // One isolated access on a single port, starting from IDLE. The checks
    // cover every memory beat, the ack latency, the read data, and the fact
    // that the other port is left untouched.
    task automatic applyStimulus(input bit port, input bit we, input bit word,
                                 input logic [15:0] addr, input logic [15:0] wdata,
                                 input bit drop_in_lo);
        int cycles = 0;
        int beat = 0;
        bit acked = 1'b0;
        logic [15:0] exp_rd, beat_addr;
        void'(modelGrant(!port, port));
        setPort(port, 1'b1, we, word, addr, wdata);
        while (!acked && cycles < 8) begin
            @(negedge clk);
            cycles++;
            if (drop_in_lo && cycles == 1) setPort(port, 1'b0, we, word, addr, wdata);
            if (m_en) begin
                beat_addr = (beat == 0) ? addr : addr + 16'd1;
                checkOutput("m_addr", m_addr, beat_addr);
                checkOutput("m_we", m_we, we);
                if (we) checkOutput("m_wdata", m_wdata, (beat == 0) ? wdata[7:0] : wdata[15:8]);
                beat++;
            end
            if (a_ack || b_ack) begin
                acked = 1'b1;
                exp_rd = expRdata(we, word, addr);
                checkOutput("ack_port", {a_ack, b_ack}, port ? 2'b01 : 2'b10);
                checkOutput("owner", owner, port);
                checkOutput("rdata", port ? b_rdata : a_rdata, exp_rd);
                checkOutput("other_rdata", port ? a_rdata : b_rdata, hold[!port]);
                hold[port] = exp_rd;
                applyRef(we, word, addr, wdata);
            end
        end
        if (acked) checkOutput("latency", cycles, word ? 3 : 2);
        else checkOutput("ack_timeout", 0, 1);
        checkOutput("beats", beat, word ? 2 : 1);
        setPort(port, 1'b0, we, word, addr, wdata);
        checkIdleAfter();
    endtask

    bit          pend [2];
    logic        p_we [2];
    logic        p_word [2];
    logic [15:0] p_addr [2];
    logic [15:0] p_wdata [2];

    task automatic raiseRandom(input bit p);
        p_we[p]    = 1'($urandom_range(0, 1));
        p_word[p]  = 1'($urandom_range(0, 1));
        p_addr[p]  = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
        p_wdata[p] = 16'($urandom);
        pend[p]    = 1'b1;
        setPort(p, 1'b1, p_we[p], p_word[p], p_addr[p], p_wdata[p]);
    endtask

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed scenarios, then randomized contention.
    initial begin
        bit got;
        bit exp_b;
        bit w;
        logic [15:0] exp_rd;
        int rounds;

        for (int i = 0; i < 65536; i++) ref_mem[i] = initByte(16'(i));
        hold[0] = '0;
        hold[1] = '0;

        wait (mem_ready);
        repeat (3) @(negedge clk);
        checkResetState();
        rst = 1'b0;

        // A word write with both halves visible on the memory port.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b0);
        checkOutput("mem_1234", mem[16'h1234], 8'hEF);
        checkOutput("mem_1235", mem[16'h1235], 8'hBE);

        // B word read across the top of the address space.
        applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0011, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0022, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
        checkOutput("wrap_word", b_rdata, 16'h2211);

        // A byte read.
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h005A, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
        checkOutput("byte_read", a_rdata, 16'h005A);

        // Request dropped during the first beat still completes with one ack.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0300, 16'h0000, 1'b1);

        // Both requesters held: B gets every (STARVE_LIMIT+1)th grant.
        setPort(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000);
        setPort(1'b1, 1'b1, 1'b0, 1'b1, 16'h0200, 16'h0000);
        for (int g = 0; g < 10; g++) begin
            exp_b = modelGrant(1'b1, 1'b1);
            waitAck(got);
            if (!got) begin
                checkOutput("starve_timeout", 0, 1);
                break;
            end
            checkOutput("starve_order", {a_ack, b_ack}, exp_b ? 2'b01 : 2'b10);
            exp_rd = exp_b ? expRdata(1'b0, 1'b1, 16'h0200) : expRdata(1'b0, 1'b0, 16'h0100);
            checkOutput("starve_rdata", exp_b ? b_rdata : a_rdata, exp_rd);
            hold[exp_b] = exp_rd;
        end
        setPort(1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000);
        setPort(1'b1, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0000);
        checkIdleAfter();

        // Reset during the high beat of a word write: only the low byte lands.
        void'(modelGrant(1'b1, 1'b0));
        setPort(1'b0, 1'b1, 1'b1, 1'b1, 16'h0020, 16'hCAFE);
        @(negedge clk);
        checkOutput("rst_lo_addr", m_addr, 16'h0020);
        @(negedge clk);
        checkOutput("rst_hi_addr", m_addr, 16'h0021);
        rst = 1'b1;
        setPort(1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'hCAFE);
        @(negedge clk);
        checkResetState();
        model_streak = 0;
        hold[0] = '0;
        hold[1] = '0;
        ref_mem[16'h0020] = 8'hFE;
        checkOutput("mem_0020", mem[16'h0020], 8'hFE);
        checkOutput("mem_0021", mem[16'h0021], initByte(16'h0021));
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0);

        // Randomized contention against the transaction-level model.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        rounds = 0;
        while (rounds < 40 || pend[0] || pend[1]) begin
            if (rounds < 40) begin
                for (int p = 0; p < 2; p++)
                    if (!pend[p] && $urandom_range(0, 1) == 1) raiseRandom(p[0]);
                if (!pend[0] && !pend[1]) raiseRandom(1'($urandom_range(0, 1)));
            end
            rounds++;
            exp_b = modelGrant(pend[0], pend[1]);
            waitAck(got);
            if (!got) begin
                checkOutput("arb_timeout", 0, 1);
                break;
            end
            w = exp_b;
            checkOutput("arb_winner", {a_ack, b_ack}, w ? 2'b01 : 2'b10);
            exp_rd = expRdata(p_we[w], p_word[w], p_addr[w]);
            checkOutput("arb_rdata", w ? b_rdata : a_rdata, exp_rd);
            checkOutput("arb_other_rdata", w ? a_rdata : b_rdata, hold[!w]);
            hold[w] = exp_rd;
            applyRef(p_we[w], p_word[w], p_addr[w], p_wdata[w]);
            pend[w] = 1'b0;
            setPort(w, 1'b0, p_we[w], p_word[w], p_addr[w], p_wdata[w]);
        end
        setPort(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        setPort(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkIdleAfter();

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive A grants while b_req is pending.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port a_req, input, 1 bit: CPU requester access request, held until a_ack.
REQ-005 SHALL have a_we (input, 1: write), a_word (input, 1: 1=16-bit, 0=byte), a_addr (input, 16), a_wdata (input, 16).
REQ-006 SHALL have a_ack (output, 1: one-cycle completion pulse) and a_rdata (output, 16: read data, valid while a_ack=1).
REQ-007 SHALL have b_req, b_we, b_word, b_addr, b_wdata, b_ack, b_rdata for the debug/loader requester, identical in width and meaning to the A ports.
REQ-008 SHALL have m_en (output, 1), m_we (output, 1), m_addr (output, 16) and m_wdata (output, 8): byte-wide single-port memory drive.
REQ-009 SHALL have m_rdata (input, 8): memory read byte, valid the cycle after an m_en=1, m_we=0 cycle.
REQ-010 SHALL have busy (output, 1: FSM not IDLE) and owner (output, 1: 0=A, 1=B, current or last grant).

Function
REQ-011 SHALL implement FSM states IDLE, LO, HI and RESP; all outputs registered or decoded from state only.
REQ-012 SHALL arbitrate in IDLE when any req=1: grant A unless a_req=0, or b_req=1 and streak==STARVE_LIMIT.
REQ-013 SHALL latch the winner's we, word, addr and wdata on grant, set owner, and go to LO; latched fields are ignored after grant.
REQ-014 SHALL increment streak on an A grant while b_req=1, and clear it on a B grant or on an A grant with b_req=0; streak saturates at STARVE_LIMIT.
REQ-015 SHALL, in LO, drive m_en=1, m_we=we, m_addr=addr and m_wdata=wdata[7:0]; next state is HI if word=1, else RESP.
REQ-016 SHALL, in HI, drive m_en=1, m_we=we, m_addr=addr+1 (16-bit wrap, 0xFFFF->0x0000) and m_wdata=wdata[15:8]; capture m_rdata as the low byte when reading; next state is RESP.
REQ-017 SHALL, in RESP, drive m_en=0 and pulse the owner's ack for exactly one cycle; next state is IDLE.
REQ-018 SHALL present rdata with ack: word read = {hi, lo}, little-endian; byte read = {8'h00, byte}; write = 16'h0000.
REQ-019 SHALL, on a byte read, capture m_rdata in RESP; on a word read, capture the high byte in RESP.
REQ-020 SHALL have latency, request-in-IDLE edge to ack: byte access 2 cycles, word access 3 cycles.
REQ-021 SHALL keep m_en=0 in IDLE and RESP, so there is at most one memory access per cycle.
REQ-022 SHALL hold the non-owner's ack at 0 and leave the non-owner's rdata unchanged.
REQ-023 SHALL treat a req held after ack as a new request, arbitrated in the following IDLE cycle.
REQ-024 SHALL, on simultaneous a_req and b_req with streak<STARVE_LIMIT, grant A.
REQ-025 SHALL NOT alter an in-flight transaction when a req drops before ack; the access completes and the ack is still issued.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, force state IDLE, streak=0, owner=0, busy=0, m_en=0, m_we=0, m_addr=0, m_wdata=0, acks=0 and rdata=0.
REQ-027 SHALL abandon any in-flight access on rst with no ack issued; a word write interrupted after LO leaves only the low byte written.
REQ-028 SHALL accept a new arbitration on the first edge after rst deasserts.

Verification
REQ-029 SHALL pass directed test: A word write addr=0x1234, wdata=0xBEEF -> LO writes 0xEF@0x1234, HI writes 0xBE@0x1235, a_ack 3 cycles after request.
REQ-030 SHALL pass directed test: preload 0xFFFF=0x11, 0x0000=0x22; B word read addr=0xFFFF -> b_rdata=0x2211 with b_ack, m_addr sequence 0xFFFF, 0x0000.
REQ-031 SHALL pass directed test: A byte read addr=0x0010 holding 0x5A -> a_rdata=0x005A, a_ack 2 cycles after request.
REQ-032 SHALL pass directed test: a_req and b_req held continuously, STARVE_LIMIT=4 -> grant order A,A,A,A,B,A,A,A,A,B.
REQ-033 SHALL pass directed test: rst pulsed during HI of an A word write 0xCAFE@0x0020 -> no a_ack, 0x0020=0xFE, 0x0021 unchanged, all outputs at reset values.
REQ-034 SHALL pass directed test: a_req dropped during LO -> access completes, a_ack still pulses once, next IDLE idles.
